inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 116 +++++++++++
 tb/tb_inst_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Small instruction queue between the IF and ID stages. Entries from IF are
//   written at the tail and presented to ID from the head with a registered
//   count. Once an exception-flagged entry is accepted, further pushes are
//   blocked until a flush. A flush empties the queue and takes priority over
//   push and pop. Reset takes priority over everything.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   synchronous, active-high reset
//   fs_to_ds_valid  in   IF presents an entry
//   fs_to_ds_bus    in   entry payload (bit 64 = fetch exception, 31:0 = PC)
//   iq_allowin      out  queue accepts an entry this cycle (IF's ds_allowin)
//   iq_to_ds_valid  out  head entry valid toward ID
//   iq_to_ds_bus    out  head entry payload
//   ds_allowin      in   ID accepts the head entry this cycle
//   flush           in   back-end cancel (exception, ertn, taken branch)
//   iq_count        out  number of occupied entries (registered)
//   iq_ex_block     out  exception-flagged entry accepted, pushes blocked
// ---------------------------------------------------------------------------
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 74
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fs_to_ds_valid,
  input  logic [BUS_WD-1:0]        fs_to_ds_bus,
  output logic                     iq_allowin,
  output logic                     iq_to_ds_valid,
  output logic [BUS_WD-1:0]        iq_to_ds_bus,
  input  logic                     ds_allowin,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic                     iq_ex_block
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BUS_WD-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ex_block_q, ex_block_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Allowin is purely combinational from registered state and flush; a pop in
  // the same cycle does not open a slot when full.
  assign iq_allowin     = ~full & ~ex_block_q & ~flush;
  assign iq_to_ds_valid = ~empty & ~flush;
  assign iq_to_ds_bus   = mem_q[head_q];
  assign iq_count       = count_q;
  assign iq_ex_block    = ex_block_q;

  assign push = fs_to_ds_valid & iq_allowin;
  assign pop  = iq_to_ds_valid & ds_allowin;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ex_block_d = ex_block_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      ex_block_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        if (fs_to_ds_bus[64]) begin
          ex_block_d = 1'b1;
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ex_block_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ex_block_q <= ex_block_d;
    end
  end

  // Entry storage carries no reset; validity comes only from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= fs_to_ds_bus;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 74;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              fs_to_ds_valid;
  logic [BUS_WD-1:0] fs_to_ds_bus;
  logic              iq_allowin;
  logic              iq_to_ds_valid;
  logic [BUS_WD-1:0] iq_to_ds_bus;
  logic              ds_allowin;
  logic              flush;
  logic [CW-1:0]     iq_count;
  logic              iq_ex_block;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: expected entries in FIFO order, plus model block flag
  logic [BUS_WD-1:0] q_exp[$];
  logic              m_block;

  inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk           (clk),
    .reset         (reset),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus  (fs_to_ds_bus),
    .iq_allowin    (iq_allowin),
    .iq_to_ds_valid(iq_to_ds_valid),
    .iq_to_ds_bus  (iq_to_ds_bus),
    .ds_allowin    (ds_allowin),
    .flush         (flush),
    .iq_count      (iq_count),
    .iq_ex_block   (iq_ex_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic ex);
    logic [BUS_WD-1:0] b;
    b = '0;
    b[31:0]  = pc;
    b[63:32] = ~pc;
    b[64]    = ex;
    b[73:65] = pc[10:2];
    return b;
  endfunction

  // Monitor: inputs change just after posedge, so values at negedge are the
  // ones the DUT sees at the next posedge.
  always @(negedge clk) begin
    logic exp_allow;
    logic exp_valid;
    if (reset) begin
      q_exp.delete();
      m_block = 1'b0;
    end else begin
      exp_allow = (q_exp.size() != DEPTH) && !m_block && !flush;
      exp_valid = (q_exp.size() != 0) && !flush;
      n_cmp++;
      if (iq_allowin !== exp_allow) begin
        n_fail++;
        $display("FAIL mon_allowin @%0t: got %b expected %b", $time, iq_allowin, exp_allow);
      end
      n_cmp++;
      if (iq_to_ds_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL mon_valid @%0t: got %b expected %b", $time, iq_to_ds_valid, exp_valid);
      end
      n_cmp++;
      if (iq_count !== CW'(q_exp.size())) begin
        n_fail++;
        $display("FAIL mon_count @%0t: got %0d expected %0d", $time, iq_count, q_exp.size());
      end
      n_cmp++;
      if (iq_ex_block !== m_block) begin
        n_fail++;
        $display("FAIL mon_ex_block @%0t: got %b expected %b", $time, iq_ex_block, m_block);
      end
      if (exp_valid && ds_allowin) begin
        n_cmp++;
        if (iq_to_ds_bus !== q_exp[0]) begin
          n_fail++;
          $display("FAIL mon_order @%0t: got %h expected %h", $time, iq_to_ds_bus, q_exp[0]);
        end
        void'(q_exp.pop_front());
      end
      if (exp_allow && fs_to_ds_valid) begin
        q_exp.push_back(fs_to_ds_bus);
        if (fs_to_ds_bus[64]) m_block = 1'b1;
      end
      if (flush) begin
        q_exp.delete();
        m_block = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    ds_allowin     = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (iq_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
    n_cmp++;
    if (iq_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", iq_to_ds_valid); end
    n_cmp++;
    if (iq_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", iq_allowin); end
    n_cmp++;
    if (iq_ex_block !== 1'b0) begin n_fail++; $display("FAIL reset_ex_block: got %b expected 0", iq_ex_block); end
    tick();
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    ds_allowin = 1'b0;
    for (int i = 0; i < n; i++) begin
      fs_to_ds_valid = 1'b1;
      fs_to_ds_bus   = mk(base + 32'(4 * i), 1'b0);
      tick();
    end
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic drain();
    fs_to_ds_valid = 1'b0;
    ds_allowin     = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    ds_allowin = 1'b0;
  endtask

  task automatic test_fill_drain();
    push_n(4, 32'h1c00_0000);
    #1;
    n_cmp++;
    if (iq_count !== CW'(4)) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", iq_count); end
    n_cmp++;
    if (iq_allowin !== 1'b0) begin n_fail++; $display("FAIL fill_allowin: got %b expected 0", iq_allowin); end
    ds_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (iq_to_ds_bus[31:0] !== 32'h1c00_0000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL drain_pc%0d: got %h expected %h", i, iq_to_ds_bus[31:0], 32'h1c00_0000 + 32'(4 * i));
      end
      tick();
    end
    ds_allowin = 1'b0;
    #1;
    n_cmp++;
    if (iq_count !== '0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", iq_count); end
  endtask

  task automatic test_wrap();
    push_n(2, 32'h1c00_0100);
    fs_to_ds_valid = 1'b1;
    ds_allowin     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fs_to_ds_bus = mk(32'h1c00_0108 + 32'(4 * i), 1'b0);
      #1;
      n_cmp++;
      if (iq_to_ds_bus[31:0] !== 32'h1c00_0100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL wrap_pc%0d: got %h expected %h", i, iq_to_ds_bus[31:0], 32'h1c00_0100 + 32'(4 * i));
      end
      tick();
      n_cmp++;
      if (iq_count !== CW'(2)) begin n_fail++; $display("FAIL wrap_count%0d: got %0d expected 2", i, iq_count); end
    end
    drain();
  endtask

  task automatic test_full_pop();
    push_n(4, 32'h1c00_0200);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = mk(32'h1c00_0210, 1'b0);
    ds_allowin     = 1'b1;
    #1;
    n_cmp++;
    if (iq_allowin !== 1'b0) begin n_fail++; $display("FAIL fullpop_allowin: got %b expected 0", iq_allowin); end
    tick();
    fs_to_ds_valid = 1'b0;
    ds_allowin     = 1'b0;
    n_cmp++;
    if (iq_count !== CW'(3)) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 3", iq_count); end
    drain();
  endtask

  task automatic test_ex_block();
    ds_allowin     = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = mk(32'h1c00_0010, 1'b1);
    tick();
    n_cmp++;
    if (iq_ex_block !== 1'b1) begin n_fail++; $display("FAIL ex_set: got %b expected 1", iq_ex_block); end
    fs_to_ds_bus = mk(32'h1c00_0014, 1'b0);
    #1;
    n_cmp++;
    if (iq_allowin !== 1'b0) begin n_fail++; $display("FAIL ex_allowin: got %b expected 0", iq_allowin); end
    tick();
    fs_to_ds_valid = 1'b0;
    n_cmp++;
    if (iq_count !== CW'(1)) begin n_fail++; $display("FAIL ex_count: got %0d expected 1", iq_count); end
    ds_allowin = 1'b1;
    #1;
    n_cmp++;
    if (iq_to_ds_bus[64] !== 1'b1 || iq_to_ds_bus[31:0] !== 32'h1c00_0010) begin
      n_fail++;
      $display("FAIL ex_head: got ex=%b pc=%h expected ex=1 pc=1c000010", iq_to_ds_bus[64], iq_to_ds_bus[31:0]);
    end
    tick();
    ds_allowin = 1'b0;
    n_cmp++;
    if (iq_ex_block !== 1'b1) begin n_fail++; $display("FAIL ex_hold: got %b expected 1", iq_ex_block); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if (iq_ex_block !== 1'b0 || iq_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_clear: got block=%b allowin=%b expected block=0 allowin=1", iq_ex_block, iq_allowin);
    end
  endtask

  task automatic test_flush();
    push_n(3, 32'h1c00_0300);
    flush          = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = mk(32'h1c00_030c, 1'b1);
    ds_allowin     = 1'b1;
    #1;
    n_cmp++;
    if (iq_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", iq_to_ds_valid); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (iq_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", iq_count); end
    n_cmp++;
    if (iq_ex_block !== 1'b0) begin n_fail++; $display("FAIL flush_ex_block: got %b expected 0", iq_ex_block); end
    n_cmp++;
    if (iq_allowin !== 1'b1 || iq_to_ds_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got allowin=%b valid=%b expected allowin=1 valid=0", iq_allowin, iq_to_ds_valid);
    end
  endtask

  task automatic test_reset_mid();
    push_n(1, 32'h1c00_0400);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = mk(32'h1c00_0404, 1'b1);
    tick();
    n_cmp++;
    if (iq_count !== CW'(2) || iq_ex_block !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got count=%0d block=%b expected count=2 block=1", iq_count, iq_ex_block);
    end
    reset          = 1'b1;
    fs_to_ds_bus   = mk(32'h1c00_0408, 1'b0);
    ds_allowin     = 1'b1;
    flush          = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (iq_count !== '0 || iq_to_ds_valid !== 1'b0 || iq_allowin !== 1'b1 || iq_ex_block !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_post: got count=%0d valid=%b allowin=%b block=%b expected 0 0 1 0",
               iq_count, iq_to_ds_valid, iq_allowin, iq_ex_block);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    pc = 32'h1c00_1000;
    for (int i = 0; i < 300; i++) begin
      fs_to_ds_valid = 1'($urandom_range(0, 3) != 0);
      ds_allowin     = 1'($urandom_range(0, 2) != 0);
      flush          = 1'($urandom_range(0, 15) == 0);
      fs_to_ds_bus   = mk(pc, 1'($urandom_range(0, 24) == 0));
      pc = pc + 32'd4;
      tick();
    end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    m_block = 1'b0;
    idle();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_ex_block();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
